// File: rtl/note_scroll_queue_pkg.sv
// Shared types and constants for the note scroll queue: note ROM, LFSR tap
// table and draw sequencer state encoding.
package note_scroll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_SINGLE,
        ST_DONE
    } draw_state_e;

    localparam int NUM_NOTES = 16;

    localparam logic [7:0] NOTE_ROM [NUM_NOTES] = '{
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42,
        8'h4B, 8'h4C, 8'h52, 8'h1D, 8'h24, 8'h2C, 8'h35, 8'h3C
    };

    function automatic logic [7:0] note_lookup(input logic [3:0] idx);
        return NOTE_ROM[idx];
    endfunction

    // Maximal-length Fibonacci tap masks, bit i set means state bit i feeds back.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            default: return 32'h0000_000C;
        endcase
    endfunction

endpackage

// File: rtl/note_scroll_queue_if.sv
// Control/handshake bundle between the game datapath and the note scroll queue.
interface note_scroll_queue_if #(
    parameter int LANES  = 4,
    parameter int CODE_W = 8
);
    logic                      restart;
    logic                      advance;
    logic                      key_valid;
    logic [CODE_W-1:0]         key_code;
    logic                      draw_ack;
    logic [LANES-1:0]          draw_req;
    logic [LANES*CODE_W-1:0]   lane_code;
    logic [LANES-1:0]          lane_valid;
    logic [CODE_W-1:0]         scancode_out;
    logic                      busy;
    logic                      finish_update;
    logic                      hit;
    logic                      miss;
    logic                      overrun;

    modport master (
        output restart, advance, key_valid, key_code, draw_ack,
        input  draw_req, lane_code, lane_valid, scancode_out, busy,
               finish_update, hit, miss, overrun
    );

    modport slave (
        input  restart, advance, key_valid, key_code, draw_ack,
        output draw_req, lane_code, lane_valid, scancode_out, busy,
               finish_update, hit, miss, overrun
    );
endinterface

// File: rtl/note_scroll_queue_lfsr.sv
// Free-running Fibonacci LFSR used to pick new notes; a game restart does not
// disturb it, so the note sequence keeps evolving across games.
module note_lfsr import note_scroll_pkg::*; #(
    parameter int             W    = 4,
    parameter logic [W-1:0]   SEED = W'(4'hB)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         restart_unused,
    output logic [W-1:0] rnd
);
    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] lfsr_q, lfsr_d;

    // The all-zero state is a lock-up point, so recover by reloading the seed.
    always_comb begin
        if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end else begin
            lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd = lfsr_q;

endmodule

// File: rtl/note_scroll_queue.sv
// Shift queue of note scancodes with hit/miss detection and a req/ack draw
// sequencer that asks the renderer to repaint lanes after each change.
module note_scroll_queue import note_scroll_pkg::*; #(
    parameter int                 LANES  = 4,
    parameter int                 CODE_W = 8,
    parameter int                 LFSR_W = 4,
    parameter logic [LFSR_W-1:0]  SEED   = LFSR_W'(4'hB)
) (
    input  logic                 clk,
    input  logic                 reset,
    note_scroll_queue_if.slave   bus
);
    typedef logic [CODE_W-1:0] code_t;

    code_t            lane_code_q [LANES];
    code_t            lane_code_d [LANES];
    logic [LANES-1:0] lane_valid_q, lane_valid_d;
    logic [LANES-1:0] draw_req_q, draw_req_d;
    draw_state_e      state_q, state_d;
    logic             hit_q, hit_d;
    logic             miss_q, miss_d;
    logic             overrun_q, overrun_d;
    logic             finish_q, finish_d;

    logic [LFSR_W-1:0] rnd;
    code_t             new_note;
    logic              in_idle, hit_take, adv_take;

    note_lfsr #(.W(LFSR_W), .SEED(SEED)) u_lfsr (
        .clk            (clk),
        .reset          (reset),
        .restart_unused (bus.restart),
        .rnd            (rnd)
    );

    assign new_note = CODE_W'(note_lookup(4'(rnd)));

    // Hit is judged on the pre-shift target lane, so a note departing on the
    // same edge as a matching keypress is scored as a hit rather than a miss.
    always_comb begin
        in_idle  = (state_q == ST_IDLE);
        hit_take = in_idle && bus.key_valid && lane_valid_q[LANES-1]
                   && (bus.key_code == lane_code_q[LANES-1]);
        adv_take = in_idle && bus.advance;

        lane_code_d  = lane_code_q;
        lane_valid_d = lane_valid_q;
        draw_req_d   = draw_req_q;
        state_d      = state_q;
        hit_d        = hit_take;
        miss_d       = adv_take && lane_valid_q[LANES-1] && !hit_take;
        overrun_d    = bus.advance && !in_idle;
        finish_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (adv_take) begin
                    for (int i = LANES - 1; i > 0; i--) begin
                        lane_code_d[i] = lane_code_q[i-1];
                    end
                    lane_code_d[0] = new_note;
                    lane_valid_d   = {lane_valid_q[LANES-2:0], 1'b1};
                    draw_req_d     = LANES'(1);
                    state_d        = ST_SWEEP;
                end else if (hit_take) begin
                    lane_valid_d[LANES-1] = 1'b0;
                    draw_req_d            = LANES'(1) << (LANES - 1);
                    state_d               = ST_SINGLE;
                end
            end
            ST_SWEEP: begin
                if (bus.draw_ack) begin
                    if (draw_req_q[LANES-1]) begin
                        draw_req_d = '0;
                        state_d    = ST_DONE;
                        finish_d   = 1'b1;
                    end else begin
                        draw_req_d = draw_req_q << 1;
                    end
                end
            end
            ST_SINGLE: begin
                if (bus.draw_ack) begin
                    draw_req_d = '0;
                    state_d    = ST_DONE;
                    finish_d   = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (bus.restart) begin
            for (int i = 0; i < LANES; i++) begin
                lane_code_d[i] = '0;
            end
            lane_valid_d = '0;
            draw_req_d   = '0;
            state_d      = ST_IDLE;
            hit_d        = 1'b0;
            miss_d       = 1'b0;
            overrun_d    = 1'b0;
            finish_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                lane_code_q[i] <= '0;
            end
            lane_valid_q <= '0;
            draw_req_q   <= '0;
            state_q      <= ST_IDLE;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            overrun_q    <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            lane_code_q  <= lane_code_d;
            lane_valid_q <= lane_valid_d;
            draw_req_q   <= draw_req_d;
            state_q      <= state_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            overrun_q    <= overrun_d;
            finish_q     <= finish_d;
        end
    end

    always_comb begin
        bus.lane_code = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.lane_code[i*CODE_W +: CODE_W] = lane_code_q[i];
        end
    end

    assign bus.lane_valid    = lane_valid_q;
    assign bus.draw_req      = draw_req_q;
    assign bus.scancode_out  = lane_code_q[LANES-1];
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.finish_update = finish_q;
    assign bus.hit           = hit_q;
    assign bus.miss          = miss_q;
    assign bus.overrun       = overrun_q;

endmodule
